// File: rtl/fifo_read_ptr_empty.sv
// Read-side control of a dual-clock FIFO: syncs the write Gray pointer into rclk and owns the read pointer.
// Flags/level are registered one edge after a read; a wptr change reaches rempty on the 3rd rclk edge.
module fifo_read_ptr_empty #(
   parameter int ASIZE = 4
) (
   input  logic             rclk,
   input  logic             Rrst_n,
   input  logic             rinc,
   input  logic [ASIZE:0]   wptr_gray,
   output logic [ASIZE-1:0] raddr,
   output logic [ASIZE:0]   rptr_gray,
   output logic             rempty,
   output logic [ASIZE:0]   rlevel,
   output logic             runderflow
);

   logic [ASIZE:0] wq1_q, wq2_q;
   logic [ASIZE:0] rbin_q, rbin_d;
   logic [ASIZE:0] rptr_gray_q, rptr_gray_d;
   logic           rempty_q, rempty_d;
   logic [ASIZE:0] rlevel_q, rlevel_d;
   logic           runderflow_q, runderflow_d;
   logic [ASIZE:0] wbin_s;
   logic           rd_ok;

   always_comb begin
      rd_ok        = rinc & ~rempty_q;
      rbin_d       = rbin_q + {{ASIZE{1'b0}}, rd_ok};
      rptr_gray_d  = (rbin_d >> 1) ^ rbin_d;
      rempty_d     = (rptr_gray_d == wq2_q);
      // Binary bit i of a Gray code is the XOR of Gray bits i and above.
      wbin_s = '0;
      for (int i = 0; i <= ASIZE; i++) begin
         wbin_s[i] = ^(wq2_q >> i);
      end
      rlevel_d     = wbin_s - rbin_d;
      runderflow_d = runderflow_q | (rinc & rempty_q);
   end

   always_ff @(posedge rclk or negedge Rrst_n) begin
      if (!Rrst_n) begin
         wq1_q        <= '0;
         wq2_q        <= '0;
         rbin_q       <= '0;
         rptr_gray_q  <= '0;
         rempty_q     <= 1'b1;
         rlevel_q     <= '0;
         runderflow_q <= 1'b0;
      end else begin
         wq1_q        <= wptr_gray;
         wq2_q        <= wq1_q;
         rbin_q       <= rbin_d;
         rptr_gray_q  <= rptr_gray_d;
         rempty_q     <= rempty_d;
         rlevel_q     <= rlevel_d;
         runderflow_q <= runderflow_d;
      end
   end

   assign raddr      = rbin_q[ASIZE-1:0];
   assign rptr_gray  = rptr_gray_q;
   assign rempty     = rempty_q;
   assign rlevel     = rlevel_q;
   assign runderflow = runderflow_q;

endmodule
